dct_2d_ctrl: RTL and testbench

//   Sequencer for the 16x16 2-D DCT built from two 1-D DCT datapaths (row pass, column pass).
//   - Accepts 16 pixel rows over a valid/ready handshake.
//   - Drives the row-DCT input register and writes row results into the 16x16 transpose buffer.
//   - Reads the buffer column by column into the column DCT.
//   - Presents each column result on a valid/ready output.

---
 rtl/dct_2d_ctrl.sv | 158 +++++++++++++++
 tb/tb_dct_2d_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_2d_ctrl.sv
// Control sequencer for a 16x16 2-D DCT: row pass into the transpose buffer, then column pass to the output.
// Datapaths and buffer live outside; this block owns the FSM, counters and both handshakes.
module dct_2d_ctrl #(
    parameter int N       = 16,
    parameter int AW      = 4,
    parameter int ROW_LAT = 1,
    parameter int COL_LAT = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          row_en,
    output logic          tb_we,
    output logic [AW-1:0] tb_waddr,
    output logic          tb_re,
    output logic [AW-1:0] tb_raddr,
    output logic          col_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          blk_done,
    output logic [2:0]    state_dbg
);

    // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until that edge, ready may depend on state only.

    localparam int            WW    = (COL_LAT > 0) ? $clog2(COL_LAT + 1) : 1;
    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [WW-1:0] WMAX  = WW'(COL_LAT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROW      = 3'd1,
        FLUSH    = 3'd2,
        COL_RD   = 3'd3,
        COL_WAIT = 3'd4,
        COL_OUT  = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [AW-1:0]      r, r_nxt;
    logic [AW-1:0]      c, c_nxt;
    logic [WW-1:0]      w, w_nxt;
    logic [ROW_LAT-1:0] we_pipe;
    logic [ROW_LAT-1:0] we_pend;
    logic [AW-1:0]      addr_pipe [ROW_LAT];

    assign in_ready  = (state == ROW);
    assign busy      = (state != IDLE);
    assign row_en    = in_valid & in_ready;
    assign tb_we     = we_pipe[ROW_LAT-1];
    assign tb_waddr  = addr_pipe[ROW_LAT-1];
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        c_nxt     = c;
        w_nxt     = w;
        // Writes still queued behind the one issuing this cycle.
        we_pend              = we_pipe;
        we_pend[ROW_LAT-1]   = 1'b0;
        case (state)
            IDLE: state_nxt = ROW;
            ROW: begin
                if (row_en) begin
                    if (r == LAST) state_nxt = FLUSH;
                    else           r_nxt     = r + 1'b1;
                end
            end
            FLUSH: begin
                if (we_pend == '0) begin
                    c_nxt     = '0;
                    state_nxt = COL_RD;
                end
            end
            COL_RD: begin
                w_nxt     = '0;
                state_nxt = COL_WAIT;
            end
            COL_WAIT: begin
                if (w == WMAX) state_nxt = COL_OUT;
                else           w_nxt     = w + 1'b1;
            end
            COL_OUT: begin
                if (out_valid && out_ready) begin
                    if (c == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        c_nxt     = c + 1'b1;
                        state_nxt = COL_RD;
                    end
                end
            end
            DONE: begin
                r_nxt     = '0;
                state_nxt = ROW;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            r     <= '0;
            c     <= '0;
            w     <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            c     <= c_nxt;
            w     <= w_nxt;
        end
    end

    // Row write pipe: matches the row-DCT latency so the address lands with its data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_pipe <= '0;
            for (int i = 0; i < ROW_LAT; i++) addr_pipe[i] <= '0;
        end else begin
            we_pipe[0]   <= row_en;
            addr_pipe[0] <= r;
            for (int i = 1; i < ROW_LAT; i++) begin
                we_pipe[i]   <= we_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    // Column-side outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tb_re     <= 1'b0;
            tb_raddr  <= '0;
            col_en    <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            blk_done  <= 1'b0;
        end else begin
            tb_re     <= (state_nxt == COL_RD);
            tb_raddr  <= (state_nxt == COL_RD) ? c_nxt : '0;
            col_en    <= (state == COL_RD) && (state_nxt == COL_WAIT);
            out_valid <= (state_nxt == COL_OUT);
            out_idx   <= (state_nxt == COL_OUT) ? c_nxt : '0;
            out_last  <= (state_nxt == COL_OUT) && (c_nxt == LAST);
            blk_done  <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_dct_2d_ctrl.sv
// Bench for dct_2d_ctrl: row writes and column results are scoreboarded against queues filled from accepted rows.
module tb_dct_2d_ctrl;

    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, row_en, tb_we, tb_re, col_en, out_valid, out_last, busy, blk_done;
    logic [AW-1:0] tb_waddr, tb_raddr, out_idx;
    logic [2:0]    state_dbg;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;

    logic [AW-1:0] wr_q  [$];
    logic [AW-1:0] exp_q [$];
    int acc_cnt = 0;
    int rd_exp = 0;
    int we_cnt = 0;
    int first_acc = 0;
    int last_acc = 0;
    logic prev_row_en = 1'b0;
    logic prev_last_acc = 1'b0;

    dct_2d_ctrl #(.N(N), .AW(AW), .ROW_LAT(1), .COL_LAT(2)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .row_en(row_en),
        .tb_we(tb_we), .tb_waddr(tb_waddr), .tb_re(tb_re), .tb_raddr(tb_raddr), .col_en(col_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .blk_done(blk_done), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            wr_q.delete();
            exp_q.delete();
            acc_cnt = 0;
            rd_exp = 0;
            we_cnt = 0;
            prev_row_en = 1'b0;
            prev_last_acc = 1'b0;
        end else begin
            if (tb_we || prev_row_en) check("tb_we_lat", tb_we, prev_row_en);
            if (tb_we) begin
                we_cnt++;
                if (wr_q.size() == 0) check("we_unexp", 1, 0);
                else                  check("tb_waddr", tb_waddr, wr_q.pop_front());
            end
            if (row_en) begin
                wr_q.push_back(AW'(acc_cnt));
                if (acc_cnt == 0) first_acc = cyc;
                last_acc = cyc;
                if (acc_cnt == N - 1) begin
                    for (int k = 0; k < N; k++) exp_q.push_back(AW'(k));
                    acc_cnt = 0;
                    rd_exp = 0;
                end else begin
                    acc_cnt++;
                end
            end
            if (tb_re) begin
                check("re_while_valid", out_valid, 0);
                check("tb_raddr", tb_raddr, rd_exp);
                rd_exp++;
            end
            if (blk_done || prev_last_acc) check("blk_done", blk_done, prev_last_acc);
            prev_last_acc = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexp", 1, 0);
                end else begin
                    logic [AW-1:0] e;
                    e = exp_q.pop_front();
                    check("out_idx", out_idx, e);
                    check("out_last", out_last, (e == AW'(N - 1)));
                    prev_last_acc = (e == AW'(N - 1));
                end
            end
            prev_row_en = row_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int wc;
            in_valid = 1'b1;
            wc = 0;
            while (!in_ready && wc < 200) begin
                tick();
                wc++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic check_all_zero();
        check("rst_in_ready", in_ready, 0);
        check("rst_row_en", row_en, 0);
        check("rst_tb_we", tb_we, 0);
        check("rst_tb_waddr", tb_waddr, 0);
        check("rst_tb_re", tb_re, 0);
        check("rst_tb_raddr", tb_raddr, 0);
        check("rst_col_en", col_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_blk_done", blk_done, 0);
    endtask

    // Called at posedge+1: assert reset mid-cycle, check async clear, release away from the edge.
    task automatic reset_mid();
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero();
        @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        tick();
        check("row_in_ready", in_ready, 1);
        check("row_busy", busy, 1);
    endtask

    // Consume columns; optionally stall at stall_idx and/or stop once stop_idx is presented.
    task automatic run_cols(input int stall_idx, input int stop_idx);
        int acc_cyc;
        acc_cyc = -1;
        for (int i = 0; i < N; i++) begin
            int wc;
            if (i == stall_idx) out_ready = 1'b0;
            wc = 0;
            while (!out_valid && wc < 100) begin
                tick();
                wc++;
            end
            if (!out_valid) begin
                check("out_valid_timeout", 0, 1);
                out_ready = 1'b1;
                return;
            end
            if (acc_cyc >= 0) check("col_period", cyc - acc_cyc, 5);
            if (i == stop_idx) begin
                check("stop_idx", out_idx, i);
                return;
            end
            if (i == stall_idx) begin
                for (int s = 0; s < 10; s++) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_idx", out_idx, i);
                    check("stall_no_re", tb_re, 0);
                    tick();
                end
                out_ready = 1'b1;
            end
            acc_cyc = cyc;
            tick();
            if (i == stall_idx) begin
                check("post_stall_re", tb_re, 1);
                check("post_stall_raddr", tb_raddr, i + 1);
            end
        end
        check("done_pulse", blk_done, 1);
        tick();
        check("done_in_ready", in_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int we0;
        tick();
        check_all_zero();
        @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();
        check("start_in_ready", in_ready, 1);

        // Partial block then asynchronous reset mid-run.
        send_rows(5, 0);
        check("pre_rst_busy", busy, 1);
        reset_mid();

        // Back-to-back rows, full column pass.
        we0 = we_cnt;
        send_rows(N, 0);
        check("in_ready_drop", in_ready, 0);
        check("row_en_span", last_acc - first_acc, N - 1);
        tick();
        check("we_count_b2b", we_cnt - we0, N);
        run_cols(-1, -1);

        // Rows with gaps, column pass with a 10-cycle stall at idx 5.
        we0 = we_cnt;
        send_rows(N, 1);
        tick();
        check("we_count_gap", we_cnt - we0, N);
        run_cols(5, -1);

        // Reset while idx 7 is presented, then a fresh block.
        send_rows(N, 0);
        run_cols(-1, 7);
        reset_mid();
        we0 = we_cnt;
        send_rows(N, $urandom_range(0, 2));
        check("post_rst_no_valid", out_valid, 0);
        tick();
        check("we_count_fresh", we_cnt - we0, N);
        run_cols(-1, -1);

        repeat (3) tick();
        check("wr_q_empty", wr_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
